// File: rtl/pixel_sender_pkg.sv
// Shared widths, the RGB word type and the pixel_sender FSM state encoding.
package MyDefine;
    localparam int IMG_BIT     = 8;
    localparam int TAG_BIT     = 4;
    localparam int IMG_SIZE    = 16;
    localparam int CL_IMG_SIZE = $clog2(IMG_SIZE + 1);
    localparam int TYPE_BIT    = 2;
    localparam int SUM_BIT     = IMG_BIT + CL_IMG_SIZE;
    localparam int ADDR_BIT    = 12;

    // index 0 = R, 1 = G, 2 = B
    typedef logic [2:0][IMG_BIT-1:0] rgb_t;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        WAIT_RES
    } state_t;
endpackage

// File: rtl/pixel_fifo2.sv
// Two-entry RGB FIFO between the pixel memory read port and the downstream handshake.
module pixel_fifo2
    import MyDefine::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  rgb_t       wdata,
    input  logic       pop,
    output rgb_t       rdata,
    output logic       empty,
    output logic [1:0] count
);

    rgb_t       mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] cnt;
    logic       pop_ok;

    assign pop_ok = pop && (cnt != 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop_ok})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign empty = (cnt == 2'd0);
    assign count = cnt;

endmodule

// File: rtl/pixel_sender.sv
// Fetches one IMG_SIZE-pixel image from memory, streams it downstream with
// valid/ready, then waits for and registers the downstream result.
module pixel_sender
    import MyDefine::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   job_valid,
    output logic                   job_ready,
    input  logic [TAG_BIT-1:0]     job_tag,
    input  logic [ADDR_BIT-1:0]    job_base,
    output logic                   mem_req,
    output logic [ADDR_BIT-1:0]    mem_addr,
    input  rgb_t                   mem_rdata,
    output logic                   pixel_valid,
    input  logic                   pixel_ready,
    output rgb_t                   pixel_data,
    output logic [TAG_BIT-1:0]     pixel_tag,
    input  logic                   img_valid,
    input  logic [TAG_BIT-1:0]     img_tag,
    input  logic [TYPE_BIT-1:0]    img_type,
    input  logic [CL_IMG_SIZE-1:0] img_num,
    input  logic [SUM_BIT-1:0]     img_sum,
    output logic                   done_valid,
    output logic [TAG_BIT-1:0]     done_tag,
    output logic [TYPE_BIT-1:0]    done_type,
    output logic [CL_IMG_SIZE-1:0] done_num,
    output logic [SUM_BIT-1:0]     done_sum,
    output logic                   done_err
);

    state_t                 state, state_nxt;
    logic [TAG_BIT-1:0]     tag_q;
    logic [ADDR_BIT-1:0]    base_q;
    logic [CL_IMG_SIZE-1:0] issue_cnt;
    logic [CL_IMG_SIZE-1:0] sent_cnt;
    logic                   in_flight;
    logic                   fifo_empty;
    logic [1:0]             fifo_count;
    logic                   xfer;
    logic [2:0]             in_use;

    pixel_fifo2 u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_flight),
        .wdata (mem_rdata),
        .pop   (xfer),
        .rdata (pixel_data),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign pixel_valid = !fifo_empty;
    assign pixel_tag   = tag_q;
    assign xfer        = pixel_valid && pixel_ready;
    assign mem_addr    = base_q + ADDR_BIT'(issue_cnt);

    // A slot being popped this cycle counts as free, so a new read can land
    // in it one cycle later; this is what sustains one pixel per cycle.
    assign in_use = 3'(fifo_count) + 3'(in_flight) - 3'(xfer);

    always_comb begin
        state_nxt = state;
        job_ready = 1'b0;
        mem_req   = 1'b0;
        case (state)
            IDLE: begin
                job_ready = 1'b1;
                if (job_valid) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                mem_req = (issue_cnt < CL_IMG_SIZE'(IMG_SIZE)) && (in_use < 3'd2);
                if (xfer && (sent_cnt == CL_IMG_SIZE'(IMG_SIZE - 1))) begin
                    state_nxt = WAIT_RES;
                end
            end
            WAIT_RES: begin
                if (img_valid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tag_q      <= '0;
            base_q     <= '0;
            issue_cnt  <= '0;
            sent_cnt   <= '0;
            in_flight  <= 1'b0;
            done_valid <= 1'b0;
            done_tag   <= '0;
            done_type  <= '0;
            done_num   <= '0;
            done_sum   <= '0;
            done_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            in_flight  <= mem_req;
            done_valid <= 1'b0;
            if (job_valid && job_ready) begin
                tag_q     <= job_tag;
                base_q    <= job_base;
                issue_cnt <= '0;
                sent_cnt  <= '0;
            end else begin
                if (mem_req) begin
                    issue_cnt <= issue_cnt + CL_IMG_SIZE'(1);
                end
                if (xfer) begin
                    sent_cnt <= sent_cnt + CL_IMG_SIZE'(1);
                end
            end
            if ((state == WAIT_RES) && img_valid) begin
                done_valid <= 1'b1;
                done_tag   <= img_tag;
                done_type  <= img_type;
                done_num   <= img_num;
                done_sum   <= img_sum;
                done_err   <= (img_tag != tag_q);
            end
        end
    end

endmodule
